iph_scheduler: RTL and testbench
================================

# iph_scheduler

Frame-level sequencer for the photovoltaic photocurrent (Iph) datapath. On each solver step it walks NUM_PANELS panel entries, fetches each panel's irradiance S and temperature T from an operand RAM, and issues them back-to-back into the fully pipelined Iph datapath. It collects the in-order results into a result RAM and raises a frame-complete pulse. It sits between the real-time step controller and the Iph datapath, which it shares across all panels by time-multiplexing.

## Interface
- SINGLE, 32: float word width (IEEE-754 single).
- NUM_PANELS, 8: panels per frame, 1..256.
- DP_LAT, 22: datapath latency, dp_sta to dp_done, in cycles.
- AW, 8: panel index width; must satisfy 2^AW >= NUM_PANELS.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame request, single-cycle pulse.
- op_rd_en  out  1  operand RAM read strobe.
- op_addr  out  AW  operand RAM address (panel index).
- op_S  in  SINGLE  irradiance, valid 1 cycle after op_rd_en.
- op_T  in  SINGLE  temperature, valid 1 cycle after op_rd_en.
- dp_sta  out  1  datapath issue strobe.
- dp_S  out  SINGLE  datapath S operand.
- dp_T  out  SINGLE  datapath T operand.
- dp_done  in  1  datapath result valid.
- dp_Iph  in  SINGLE  datapath result.
- iph_we  out  1  result RAM write enable.
- iph_addr  out  AW  result RAM address.
- iph_data  out  SINGLE  result RAM data.
- busy  out  1  frame in progress.
- frame_done  out  1  single-cycle frame-complete pulse.
- err  out  1  sticky watchdog error; tied 0 when IPH_WDT_EN is not defined.

## Operation
- States:
  - IDLE: start=1 -> ISSUE.
  - ISSUE: advance rd_idx 0..NUM_PANELS-1, one per cycle. After the last read -> DRAIN.
  - DRAIN: wait until wr_cnt==NUM_PANELS -> FIN.
  - FIN: pulse frame_done -> IDLE.
- op_rd_en=1 throughout ISSUE, with op_addr=rd_idx.
- dp_sta is op_rd_en delayed 1 cycle. dp_S and dp_T pass op_S and op_T straight through (no register). The datapath is therefore issued with every read's data in the following cycle.
- The datapath returns results in order, so no tags are carried. Each dp_done registers iph_we=1, iph_addr=wr_cnt, iph_data=dp_Iph on the next cycle, then increments wr_cnt.
- busy=1 in every state except IDLE.
- start is ignored while busy. A start arriving in the FIN cycle is also ignored.
- dp_done while IDLE is discarded: no write, no counter change. This covers stray results left over after a reset.
- rd_idx and wr_cnt clear on entry to ISSUE. No wrap occurs because the counts stop at NUM_PANELS-1 and NUM_PANELS.
- Reset mid-frame: everything returns to its reset value immediately and any in-flight results are discarded.

## Timing
- Reset values: op_rd_en, dp_sta, iph_we, busy, frame_done, err = 0. op_addr, iph_addr = 0. iph_data, dp_S, dp_T = 0. State=IDLE.
- start sampled at cycle t0. ISSUE runs t0+1..t0+NUM_PANELS. First dp_sta at t0+2.
- Last dp_done at t0+NUM_PANELS+1+DP_LAT. Last iph_we one cycle later. frame_done one cycle after that.
- Total start-to-frame_done: NUM_PANELS+DP_LAT+3 cycles (33 with defaults).
- Minimum start-to-start spacing equals that total plus 1 (the IDLE cycle).

## Configuration
- IPH_WDT_EN defined:
  - A watchdog counter runs while in DRAIN and restarts on every dp_done.
  - If it reaches DP_LAT+4 with wr_cnt<NUM_PANELS: err sets (sticky until rst), state -> FIN, frame_done pulses.
  - Unwritten result RAM entries keep their previous contents.
- IPH_WDT_EN undefined: no counter; err is constant 0; DRAIN waits indefinitely.

## Structure
- Shared package iph_pkg:
  - SINGLE constant.
  - State enum {IDLE, ISSUE, DRAIN, FIN}.
  - WDT_MARGIN=4 constant.
- Sub-module iph_wdt (counter, restart, expiry flag), instantiated only under IPH_WDT_EN.
- Everything else lives in the single top module.

## Test plan
- Nominal frame, defaults:
  - Stimulus: start at t0; operand RAM holds S=1000.0, T=25.0+k per panel; a model datapath with DP_LAT=22 returns result k.
  - Response: 8 writes at addresses 0..7 in order, data matching; frame_done at t0+33; busy high t0+1..t0+33.
- start is re-pulsed at t0+5 and again at the FIN cycle -> both ignored; exactly one frame_done.
- rst asserted at t0+15 -> all outputs return to 0 immediately. Stale dp_done pulses after release produce no iph_we. A new start then completes normally.
- NUM_PANELS=1 -> one read, one write at address 0, frame_done at t0+DP_LAT+4.
- IPH_WDT_EN with the model dropping the 6th result:
  - err rises at the cycle where the last dp_done + DP_LAT+4 is reached, and frame_done pulses in the cycle after.
  - Only addresses 0..4 are written.
  - err stays high through the next frame.
- IPH_WDT_EN undefined, same drop -> busy stays high indefinitely; err stays 0.

Source files
------------

// File: rtl/iph_pkg.sv
// Shared constants and FSM encoding for the Iph frame scheduler.
package iph_pkg;

  localparam int SINGLE     = 32;
  localparam int WDT_MARGIN = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/iph_wdt.sv
// Drain watchdog (built only with IPH_WDT_EN): counts cycles since the last result, flags
// expiry at LIMIT; one-cycle reaction, no backpressure.
module iph_wdt
  import iph_pkg::*;
#(
  parameter int LIMIT = 22 + WDT_MARGIN
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // cnt equals the number of cycles elapsed since the most recent restart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (cnt != CW'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && !restart && (cnt == CW'(LIMIT));

endmodule

// File: rtl/iph_scheduler.sv
// Frame sequencer feeding the shared Iph datapath; start-to-frame_done is NUM_PANELS+DP_LAT+3 cycles,
// no backpressure (datapath always accepts). Optional drain watchdog under IPH_WDT_EN.
module iph_scheduler
  import iph_pkg::*;
#(
  parameter int NUM_PANELS = 8,
  parameter int DP_LAT     = 22,
  parameter int AW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              op_rd_en,
  output logic [AW-1:0]     op_addr,
  input  logic [SINGLE-1:0] op_S,
  input  logic [SINGLE-1:0] op_T,
  output logic              dp_sta,
  output logic [SINGLE-1:0] dp_S,
  output logic [SINGLE-1:0] dp_T,
  input  logic              dp_done,
  input  logic [SINGLE-1:0] dp_Iph,
  output logic              iph_we,
  output logic [AW-1:0]     iph_addr,
  output logic [SINGLE-1:0] iph_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  if (NUM_PANELS < 1 || NUM_PANELS > 256 || (1 << AW) < NUM_PANELS || DP_LAT < 1) begin : g_cfg_check
    $error("iph_scheduler: unsupported parameter set");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PANELS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(NUM_PANELS);

  state_t        state, state_nxt;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   wr_cnt;
  logic          accept;
  logic          wdt_trip;

  // results arriving while idle are leftovers from an aborted frame
  assign accept = dp_done && (state != IDLE);

`ifdef IPH_WDT_EN
  logic wdt_expired;
  logic err_q;

  iph_wdt #(
    .LIMIT(DP_LAT + WDT_MARGIN)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .run    (state == DRAIN),
    .restart(dp_done),
    .expired(wdt_expired)
  );

  assign wdt_trip = (state == DRAIN) && wdt_expired && (wr_cnt != FULL_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | wdt_trip;
  end

  assign err = err_q | wdt_trip;
`else
  assign wdt_trip = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (rd_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (wr_cnt == FULL_CNT || wdt_trip) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx   <= '0;
      wr_cnt   <= '0;
      dp_sta   <= 1'b0;
      iph_we   <= 1'b0;
      iph_addr <= '0;
      iph_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_idx <= '0;
        wr_cnt <= '0;
      end else if (state == ISSUE && rd_idx != LAST_IDX) begin
        rd_idx <= rd_idx + 1'b1;
      end
      dp_sta <= op_rd_en;
      iph_we <= accept;
      if (accept) begin
        iph_addr <= wr_cnt[AW-1:0];
        iph_data <= dp_Iph;
        wr_cnt   <= wr_cnt + 1'b1;
      end
    end
  end

  assign op_rd_en   = (state == ISSUE);
  assign op_addr    = rd_idx;
  // operands reach the datapath unregistered; held at zero between issues
  assign dp_S       = dp_sta ? op_S : '0;
  assign dp_T       = dp_sta ? op_T : '0;
  assign busy       = (state != IDLE);
  assign frame_done = (state == FIN);

endmodule

// File: tb/tb_iph_scheduler.sv
// Directed bench for iph_scheduler: operand RAM and fixed-latency datapath models, write scoreboard.
`timescale 1ns/1ps
module tb_iph_scheduler;

  localparam int          DP_LAT = 22;
  localparam int          N      = 8;
  localparam int          NEVER  = 1 << 30;
  localparam logic [31:0] S_1000 = 32'h447A_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start;
  logic [1:0]  op_rd_en, dp_sta, dp_done, iph_we, busy, frame_done, err;
  logic [7:0]  op_addr [2];
  logic [7:0]  iph_addr [2];
  logic [31:0] op_S [2] = '{default: '0};
  logic [31:0] op_T [2] = '{default: '0};
  logic [31:0] dp_S [2];
  logic [31:0] dp_T [2];
  logic [31:0] dp_Iph [2];
  logic [31:0] iph_data [2];

  // T = 25.0 + k and the datapath answer k, as IEEE-754 single words
  logic [31:0] t_tab [8] = '{32'h41C8_0000, 32'h41D0_0000, 32'h41D8_0000, 32'h41E0_0000,
                             32'h41E8_0000, 32'h41F0_0000, 32'h41F8_0000, 32'h4200_0000};
  logic [31:0] res_tab [8] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                               32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};

  iph_scheduler #(.NUM_PANELS(N), .DP_LAT(DP_LAT), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start[0]),
    .op_rd_en(op_rd_en[0]), .op_addr(op_addr[0]), .op_S(op_S[0]), .op_T(op_T[0]),
    .dp_sta(dp_sta[0]), .dp_S(dp_S[0]), .dp_T(dp_T[0]),
    .dp_done(dp_done[0]), .dp_Iph(dp_Iph[0]),
    .iph_we(iph_we[0]), .iph_addr(iph_addr[0]), .iph_data(iph_data[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .err(err[0])
  );

  iph_scheduler #(.NUM_PANELS(1), .DP_LAT(DP_LAT), .AW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .op_rd_en(op_rd_en[1]), .op_addr(op_addr[1]), .op_S(op_S[1]), .op_T(op_T[1]),
    .dp_sta(dp_sta[1]), .dp_S(dp_S[1]), .dp_T(dp_T[1]),
    .dp_done(dp_done[1]), .dp_Iph(dp_Iph[1]),
    .iph_we(iph_we[1]), .iph_addr(iph_addr[1]), .iph_data(iph_data[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .err(err[1])
  );

  // ---------------- models ----------------
  logic [DP_LAT-1:0] pv [2] = '{default: '0};
  logic [31:0]       pd [2][DP_LAT];
  int unsigned       iss_cnt = 0;
  bit                drop_en = 1'b0;

  // a wrong S corrupts the answer so that operand routing is observable
  function automatic logic [31:0] dp_model(input logic [31:0] s, input logic [31:0] t);
    dp_model = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++)
      if (t_tab[k] == t) dp_model = res_tab[k] ^ s ^ S_1000;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (op_rd_en[c]) begin
        op_S[c] <= S_1000;
        op_T[c] <= t_tab[op_addr[c][2:0]];
      end
      pv[c] <= {pv[c][DP_LAT-2:0], dp_sta[c] && !(c == 0 && drop_en && iss_cnt >= 5)};
      pd[c][0] <= dp_model(dp_S[c], dp_T[c]);
      for (int i = 1; i < DP_LAT; i++) pd[c][i] <= pd[c][i-1];
    end
    if (!busy[0])      iss_cnt <= 0;
    else if (dp_sta[0]) iss_cnt <= iss_cnt + 1;
  end

  assign dp_done[0] = pv[0][DP_LAT-1];
  assign dp_done[1] = pv[1][DP_LAT-1];
  assign dp_Iph[0]  = pd[0][DP_LAT-1];
  assign dp_Iph[1]  = pd[1][DP_LAT-1];

  // ---------------- checking ----------------
  int          checks = 0;
  int          errors = 0;
  logic [39:0] q0 [$];
  logic [39:0] q1 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (iph_we[0]) begin
      if (q0.size() == 0) chk("wr0_unexpected", iph_we[0], 0);
      else                chk("wr0_addr_data", {iph_addr[0], iph_data[0]}, q0.pop_front());
    end
    if (iph_we[1]) begin
      if (q1.size() == 0) chk("wr1_unexpected", iph_we[1], 0);
      else                chk("wr1_addr_data", {iph_addr[1], iph_data[1]}, q1.pop_front());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op_rd_en"}, op_rd_en[0], 0);
    chk({tag, "_op_addr"}, op_addr[0], 0);
    chk({tag, "_dp_sta"}, dp_sta[0], 0);
    chk({tag, "_dp_S"}, dp_S[0], 0);
    chk({tag, "_dp_T"}, dp_T[0], 0);
    chk({tag, "_iph_we"}, iph_we[0], 0);
    chk({tag, "_iph_addr"}, iph_addr[0], 0);
    chk({tag, "_iph_data"}, iph_data[0], 0);
    chk({tag, "_busy"}, busy[0], 0);
    chk({tag, "_frame_done"}, frame_done[0], 0);
    chk({tag, "_err"}, err[0], 0);
  endtask

  task automatic push_frame(input int n_res);
    for (int k = 0; k < n_res; k++) q0.push_back({8'(k), res_tab[k]});
  endtask

  // caller sits in cycle t0; after the k-th step the bench observes cycle t0+k
  task automatic run_frame(input int n_cyc, input int fd_at, input int err_from, input bit repulse);
    int fd_seen = 0;
    start[0] = 1'b1;
    for (int k = 1; k <= n_cyc; k++) begin
      step();
      start[0] = repulse && (k == 5 || k == fd_at);
      chk("busy", busy[0], k <= fd_at);
      chk("frame_done", frame_done[0], k == fd_at);
      chk("op_rd_en", op_rd_en[0], k <= N);
      if (k <= N) chk("op_addr", op_addr[0], k - 1);
      chk("dp_sta", dp_sta[0], k >= 2 && k <= N + 1);
      if (k >= 2 && k <= N + 1) begin
        chk("dp_S", dp_S[0], S_1000);
        chk("dp_T", dp_T[0], t_tab[k-2]);
      end
      chk("err", err[0], k >= err_from);
      fd_seen += int'(frame_done[0]);
    end
    start[0] = 1'b0;
    chk("frame_done_count", fd_seen, fd_at <= n_cyc);
  endtask

  initial begin
    rst   = 1'b0;
    start = 2'b00;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) step();

    // nominal frame with start re-pulsed at t0+5 and in the FIN cycle
    push_frame(N);
    run_frame(40, N + DP_LAT + 3, NEVER, 1'b1);
    chk("nominal_all_written", q0.size(), 0);

    // reset in the middle of a frame, then stale results must be dropped
    push_frame(N);
    start[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      start[0] = 1'b0;
    end
    chk("pre_reset_busy", busy[0], 1);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    q0.delete();
    repeat (3) step();
    rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("stale_we", iph_we[0], 0);
      chk("stale_busy", busy[0], 0);
    end
    push_frame(N);
    run_frame(36, N + DP_LAT + 3, NEVER, 1'b0);
    chk("post_reset_all_written", q0.size(), 0);

    // single-panel instance
    q1.push_back({8'd0, res_tab[0]});
    start[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      start[1] = 1'b0;
      chk("n1_busy", busy[1], k <= DP_LAT + 4);
      chk("n1_frame_done", frame_done[1], k == DP_LAT + 4);
      chk("n1_op_rd_en", op_rd_en[1], k == 1);
      chk("n1_op_addr", op_addr[1], 0);
    end
    chk("n1_all_written", q1.size(), 0);

    // datapath loses the 6th and later results
    drop_en = 1'b1;
    push_frame(5);
`ifdef IPH_WDT_EN
    run_frame(58, 55, 54, 1'b0);
    chk("wdt_partial_written", q0.size(), 0);
    drop_en = 1'b0;
    push_frame(N);
    run_frame(36, N + DP_LAT + 3, 0, 1'b0);
    chk("wdt_next_frame_written", q0.size(), 0);
`else
    run_frame(80, NEVER, NEVER, 1'b0);
    chk("hang_partial_written", q0.size(), 0);
    drop_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("hang_reset_busy", busy[0], 0);
    q0.delete();
    step();
    rst = 1'b1;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
